// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } pll_seq_state_t;

    localparam int DEF_ARESET_CYCLES        = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES  = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES   = 1024;
    localparam int DEF_RELEASE_DELAY_CYCLES = 64;
    localparam int DEF_MAX_RETRIES          = 3;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module bit_sync (
    input  logic clk,
    input  logic areset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up/supervision FSM: pulses PLL reset, qualifies lock, releases downstream reset.
// Optional macro LOCK_LOSS_COUNT_EN adds the saturating lock_loss_cnt output.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int ARESET_CYCLES        = DEF_ARESET_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES  = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES   = DEF_LOCK_STABLE_CYCLES,
    parameter int RELEASE_DELAY_CYCLES = DEF_RELEASE_DELAY_CYCLES,
    parameter int MAX_RETRIES          = DEF_MAX_RETRIES
) (
    input  logic                               clk,
    input  logic                               areset_n,
    input  logic                               pll_locked,
    input  logic                               soft_restart,
    output logic                               pll_areset,
    output logic                               rst_out_n,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]                         lock_loss_cnt
`endif
);

    localparam int CNT_MAX = max_of4(ARESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES, RELEASE_DELAY_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    // Each phase ends on the edge where the counter holds its last value,
    // so a phase of N cycles occupies exactly N edges.
    localparam logic [CNT_W-1:0]   ARESET_LAST  = CNT_W'(ARESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    pll_seq_state_t   state;
    logic [CNT_W-1:0] phase_cnt;
    logic             locked_s;

    bit_sync u_lock_sync (
        .clk      (clk),
        .areset_n (areset_n),
        .d        (pll_locked),
        .q        (locked_s)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= RESET;
            phase_cnt   <= '0;
            retry_count <= '0;
            pll_areset  <= 1'b1;
            rst_out_n   <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else if (soft_restart) begin
            state       <= RESET;
            phase_cnt   <= '0;
            retry_count <= '0;
            pll_areset  <= 1'b1;
            rst_out_n   <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                RESET: begin
                    if (phase_cnt == ARESET_LAST) begin
                        state      <= WAIT_LOCK;
                        phase_cnt  <= '0;
                        pll_areset <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state     <= STABLE;
                        phase_cnt <= '0;
                    end else if (phase_cnt == TIMEOUT_LAST) begin
                        phase_cnt  <= '0;
                        pll_areset <= 1'b1;
                        if (retry_count < RETRY_LIMIT) begin
                            state       <= RESET;
                            retry_count <= retry_count + 1'b1;
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state     <= WAIT_LOCK;
                        phase_cnt <= '0;
                    end else if (phase_cnt == STABLE_LAST) begin
                        state     <= RELEASE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!locked_s) begin
                        state      <= RESET;
                        phase_cnt  <= '0;
                        pll_areset <= 1'b1;
                    end else if (phase_cnt == RELEASE_LAST) begin
                        state     <= RUN;
                        phase_cnt <= '0;
                        rst_out_n <= 1'b1;
                        ready     <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Lock loss after a good run restarts with a fresh retry budget.
                    if (!locked_s) begin
                        state       <= RESET;
                        phase_cnt   <= '0;
                        retry_count <= '0;
                        pll_areset  <= 1'b1;
                        rst_out_n   <= 1'b0;
                        ready       <= 1'b0;
                    end
                end
                FAULT: begin
                    phase_cnt <= '0;
                end
                default: begin
                    state       <= RESET;
                    phase_cnt   <= '0;
                    retry_count <= '0;
                    pll_areset  <= 1'b1;
                    rst_out_n   <= 1'b0;
                    ready       <= 1'b0;
                    fault       <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    // Survives soft_restart so field diagnostics keep the history.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            lock_loss_cnt <= 8'd0;
        end else if (!soft_restart && state == RUN && !locked_s && lock_loss_cnt != 8'hFF) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule
